// File: rtl/neureka_normquant_mult_sched_if.sv
// Handshake bundle between a pass controller / writeback stage and the
// normquant multiplier scheduler.
interface neureka_normquant_mult_sched_if #(
    parameter int unsigned NCH = 32
);
    localparam int unsigned IDXW = $clog2(NCH);
    localparam int unsigned CNTW = IDXW + 1;

    logic            start_i;
    logic            clear_i;
    logic [CNTW-1:0] num_ch_i;
    logic            busy_o;
    logic            done_o;
    logic [IDXW-1:0] acc_idx_o;
    logic            mult_enable_o;
    logic            mult_clear_o;
    logic            wb_valid_o;
    logic [IDXW-1:0] wb_idx_o;
    logic            wb_ready_i;

    modport master (
        output start_i, clear_i, num_ch_i, wb_ready_i,
        input  busy_o, done_o, acc_idx_o, mult_enable_o, mult_clear_o,
               wb_valid_o, wb_idx_o
    );

    modport slave (
        input  start_i, clear_i, num_ch_i, wb_ready_i,
        output busy_o, done_o, acc_idx_o, mult_enable_o, mult_clear_o,
               wb_valid_o, wb_idx_o
    );
endinterface

// File: rtl/neureka_normquant_mult_sched.sv
// Time-multiplexes one normquant multiplier across NCH accumulator channels,
// issuing one channel per cycle and forwarding tagged products to writeback.
module neureka_normquant_mult_sched #(
    parameter int unsigned NCH  = 32,
    parameter int unsigned PIPE = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    neureka_normquant_mult_sched_if.slave bus
);
    localparam int unsigned IDXW = $clog2(NCH);
    localparam int unsigned CNTW = IDXW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] n_q, n_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            mclr_q;
    logic [CNTW-1:0] num_clamped;
    logic            advance;
    logic            drain_ack;
    logic            issue;
    logic            last;

    assign num_clamped = (bus.num_ch_i > CNTW'(NCH)) ? CNTW'(NCH) : bus.num_ch_i;
    assign issue       = (state_q == ISSUE) && advance;
    assign last        = ((CNTW'(idx_q) + CNTW'(1)) == n_q);

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    n_d     = num_clamped;
                    idx_d   = '0;
                    state_d = (num_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    if (last) state_d = (PIPE == 0) ? DONE : DRAIN;
                    else      idx_d   = idx_q + IDXW'(1);
                end
            end
            DRAIN: begin
                if (drain_ack) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            mclr_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            mclr_q  <= (state_q == DONE);
        end
    end

    // One-slot product stage; a held slot freezes tag and blocks new issues
    if (PIPE != 0) begin : g_pipe
        logic            wb_valid_q;
        logic [IDXW-1:0] wb_idx_q;

        assign advance   = !wb_valid_q || bus.wb_ready_i;
        assign drain_ack = wb_valid_q && bus.wb_ready_i;

        always_ff @(posedge clk_i) begin
            if (rst_i || bus.clear_i) begin
                wb_valid_q <= 1'b0;
                wb_idx_q   <= '0;
            end else if (advance) begin
                wb_valid_q <= issue;
                if (issue) wb_idx_q <= idx_q;
            end
        end

        assign bus.wb_valid_o = wb_valid_q;
        assign bus.wb_idx_o   = wb_idx_q;
    end else begin : g_comb
        assign advance        = bus.wb_ready_i;
        assign drain_ack      = 1'b0;
        assign bus.wb_valid_o = issue;
        assign bus.wb_idx_o   = idx_q;
    end

    assign bus.busy_o        = (state_q != IDLE);
    assign bus.done_o        = (state_q == DONE);
    assign bus.mult_enable_o = issue;
    assign bus.acc_idx_o     = idx_q;
    assign bus.mult_clear_o  = mclr_q;
endmodule

// File: tb/tb_neureka_normquant_mult_sched.sv
// Scoreboard bench: lane 1 drives a PIPE=1 scheduler, lane 0 a PIPE=0 one;
// expected tags and done timing are queued at start, a negedge monitor checks.
module tb_neureka_normquant_mult_sched;
    localparam int unsigned NCH  = 32;
    localparam int unsigned CNTW = $clog2(NCH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    int   exp_iss[2][$];
    int   exp_wb[2][$];
    int   exp_done[2][$];
    int   done_cnt[2];
    logic prev_done[2], prev_hold[2], prev_clr[2], prev_en[2];
    int   prev_wi[2], prev_ai[2];
    logic prev_rst;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neureka_normquant_mult_sched_if #(.NCH(NCH)) p1();
    neureka_normquant_mult_sched_if #(.NCH(NCH)) p0();

    neureka_normquant_mult_sched #(.NCH(NCH), .PIPE(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(p1));
    neureka_normquant_mult_sched #(.NCH(NCH), .PIPE(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(p0));

    function automatic void chk(input int l, input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL lane%0d %s: got %0d expected %0d (cycle %0d)", l, nm, act, exp, cyc);
        end
    endfunction

    task automatic mon(input int l, input logic dn, input logic en, input logic mclr,
                       input logic wv, input logic rdy, input logic clr, input int ai, input int wi);
        int e;
        if (en) begin
            chk(l, "issue_expected", int'(exp_iss[l].size() > 0), 1);
            if (exp_iss[l].size() > 0) chk(l, "issue_idx", ai, exp_iss[l].pop_front());
        end
        if (l == 0) begin
            chk(l, "valid_eq_enable", int'(wv), int'(en));
            if (wv) chk(l, "wb_idx_eq_acc_idx", wi, ai);
        end else begin
            if (prev_en[l] && !prev_clr[l]) begin
                chk(l, "wb_follows_issue", int'(wv), 1);
                chk(l, "wb_tag_follows_issue", wi, prev_ai[l]);
            end
            if (prev_hold[l] && !prev_clr[l]) begin
                chk(l, "valid_held", int'(wv), 1);
                chk(l, "tag_held", wi, prev_wi[l]);
            end
            if (wv && !rdy) chk(l, "no_issue_in_stall", int'(en), 0);
        end
        if (wv && rdy) begin
            chk(l, "accept_expected", int'(exp_wb[l].size() > 0), 1);
            if (exp_wb[l].size() > 0) chk(l, "wb_tag", wi, exp_wb[l].pop_front());
        end
        chk(l, "mult_clear", int'(mclr), int'(prev_done[l] || prev_rst || prev_clr[l]));
        if (dn) begin
            done_cnt[l]++;
            chk(l, "done_expected", int'(exp_done[l].size() > 0), 1);
            if (exp_done[l].size() > 0) begin
                e = exp_done[l].pop_front();
                if (e >= 0) chk(l, "done_cycle", cyc, e);
                chk(l, "tags_outstanding_at_done", exp_wb[l].size(), 0);
            end
        end
        prev_done[l] = dn;
        prev_hold[l] = wv && !rdy;
        prev_clr[l]  = clr;
        prev_en[l]   = en;
        prev_ai[l]   = ai;
        prev_wi[l]   = wi;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_rst = 1'b1;
            for (int l = 0; l < 2; l++) begin
                prev_done[l] = 1'b0; prev_hold[l] = 1'b0; prev_clr[l] = 1'b0; prev_en[l] = 1'b0;
            end
        end else begin
            mon(1, p1.done_o, p1.mult_enable_o, p1.mult_clear_o, p1.wb_valid_o, p1.wb_ready_i,
                p1.clear_i, int'(p1.acc_idx_o), int'(p1.wb_idx_o));
            mon(0, p0.done_o, p0.mult_enable_o, p0.mult_clear_o, p0.wb_valid_o, p0.wb_ready_i,
                p0.clear_i, int'(p0.acc_idx_o), int'(p0.wb_idx_o));
            prev_rst = 1'b0;
        end
    end

    task automatic set_ctl(input int l, input logic st, input int n, input logic clr);
        if (l == 1) begin p1.start_i = st; p1.num_ch_i = CNTW'(n); p1.clear_i = clr; end
        else        begin p0.start_i = st; p0.num_ch_i = CNTW'(n); p0.clear_i = clr; end
    endtask

    task automatic set_rdy(input int l, input logic v);
        if (l == 1) p1.wb_ready_i = v;
        else        p0.wb_ready_i = v;
    endtask

    function automatic logic busy(input int l);
        return (l == 1) ? p1.busy_o : p0.busy_o;
    endfunction

    // Model: N clamped to NCH, tags 0..N-1 once each in order; with ready held
    // high done lands N+PIPE+1 cycles after start (1 cycle for N=0).
    task automatic start_pass(input int l, input int n, input bit timed, input int extra);
        int nc;
        nc = (n > int'(NCH)) ? int'(NCH) : n;
        @(posedge clk); #1;
        set_ctl(l, 1'b1, n, 1'b0);
        for (int i = 0; i < nc; i++) begin
            exp_iss[l].push_back(i);
            exp_wb[l].push_back(i);
        end
        if (!timed)       exp_done[l].push_back(-1);
        else if (nc == 0) exp_done[l].push_back(cyc + 1);
        else              exp_done[l].push_back(cyc + nc + l + 1 + extra);
        @(posedge clk); #1;
        set_ctl(l, 1'b0, 0, 1'b0);
    endtask

    task automatic wait_done(input int l, input bit rnd, input bit poke);
        int d0;
        bit seen;
        d0   = done_cnt[l];
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(posedge clk); #1;
            set_ctl(l, 1'b0, 0, 1'b0);
            if (done_cnt[l] != d0) seen = 1'b1;
            else begin
                if (rnd) set_rdy(l, logic'($urandom_range(0, 3) != 0));
                if (poke && k == 1 && busy(l)) set_ctl(l, 1'b1, int'($urandom_range(1, 40)), 1'b0);
            end
        end
        chk(l, "done_within_bound", int'(seen), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(1, {tag, "_busy"},     int'(p1.busy_o), 0);
        chk(1, {tag, "_done"},     int'(p1.done_o), 0);
        chk(1, {tag, "_enable"},   int'(p1.mult_enable_o), 0);
        chk(1, {tag, "_wb_valid"}, int'(p1.wb_valid_o), 0);
        chk(1, {tag, "_acc_idx"},  int'(p1.acc_idx_o), 0);
        chk(1, {tag, "_wb_idx"},   int'(p1.wb_idx_o), 0);
        chk(1, {tag, "_mclr"},     int'(p1.mult_clear_o), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int d0;
        set_ctl(1, 1'b0, 0, 1'b0); set_ctl(0, 1'b0, 0, 1'b0);
        set_rdy(1, 1'b1);          set_rdy(0, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset");

        // Back-to-back issue, then a 2-cycle stall while tag 1 is presented
        start_pass(1, 4, 1'b1, 0);
        wait_done(1, 1'b0, 1'b0);
        start_pass(1, 3, 1'b1, 2);
        repeat (2) begin @(posedge clk); #1; end
        set_rdy(1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        set_rdy(1, 1'b1);
        wait_done(1, 1'b0, 1'b0);

        // Empty pass: busy for exactly the done cycle
        d0 = done_cnt[1];
        start_pass(1, 0, 1'b1, 0);
        chk(1, "zero_pass_busy", int'(p1.busy_o), 1);
        @(posedge clk); #1;
        chk(1, "zero_pass_idle_after", int'(p1.busy_o), 0);
        chk(1, "zero_pass_one_done", done_cnt[1] - d0, 1);

        // Abort after two issues, then a clean restart
        start_pass(1, 8, 1'b1, 0);
        @(posedge clk); #1;
        set_ctl(1, 1'b0, 0, 1'b1);
        @(posedge clk); #1;
        set_ctl(1, 1'b0, 0, 1'b0);
        exp_iss[1].delete(); exp_wb[1].delete(); exp_done[1].delete();
        check_reset_outputs("abort");
        start_pass(1, 5, 1'b1, 0);
        wait_done(1, 1'b0, 1'b0);

        // Clear together with start drops the start
        @(posedge clk); #1;
        set_ctl(1, 1'b1, 6, 1'b1);
        @(posedge clk); #1;
        set_ctl(1, 1'b0, 0, 1'b0);
        chk(1, "clear_beats_start", int'(p1.busy_o), 0);
        repeat (3) @(posedge clk);

        // Oversized count clamps to NCH
        start_pass(1, 40, 1'b1, 0);
        wait_done(1, 1'b0, 1'b0);

        repeat (20) begin
            start_pass(1, int'($urandom_range(0, 40)), 1'b0, 0);
            wait_done(1, 1'b1, 1'b1);
        end
        set_rdy(1, 1'b1);

        // Zero-latency multiplier
        start_pass(0, 2, 1'b1, 0);
        wait_done(0, 1'b0, 1'b0);
        start_pass(0, 0, 1'b1, 0);
        wait_done(0, 1'b0, 1'b0);
        start_pass(0, 40, 1'b1, 0);
        wait_done(0, 1'b0, 1'b0);
        repeat (12) begin
            start_pass(0, int'($urandom_range(0, 40)), 1'b0, 0);
            wait_done(0, 1'b1, 1'b1);
        end
        set_rdy(0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        for (int l = 0; l < 2; l++) begin
            chk(l, "leftover_issues", exp_iss[l].size(), 0);
            chk(l, "leftover_tags",   exp_wb[l].size(), 0);
            chk(l, "leftover_dones",  exp_done[l].size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
